my_dmux_4_way_buf: RTL and testbench
====================================

Name: my_dmux_4_way_buf

Overview:
Buffered 4-way demultiplexer with valid/ready handshake. It is the inverse of the 4-way mux. A single 16-bit input stream is routed, word by word, to one of four output channels a/b/c/d according to a 2-bit select sampled with each word. Each channel owns a small FIFO so that one stalled consumer does not block the other channels. It sits between a single producer and four independent consumers in the datapath.

Parameters:
WIDTH, 16, data width of input and every output channel
DEPTH, 2, entries per channel FIFO; power of two, at least 2

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in  input  WIDTH  input data word
sel  input  2  destination: 0=a, 1=b, 2=c, 3=d; qualified by in_valid
in_valid  input  1  producer has a word on in/sel
in_ready  output  1  block can accept the word addressed by sel this cycle
out_a, out_b, out_c, out_d  output  WIDTH  head-of-FIFO data per channel
out_a_valid .. out_d_valid  output  1  channel FIFO non-empty
out_a_ready .. out_d_ready  input  1  consumer takes the head word this cycle

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset (reset=1 at an edge):
  - All FIFO counts and read/write pointers go to 0.
  - All out_x_valid go to 0 the next cycle.
  - in_ready is 1 after reset. During reset cycles in_ready is forced to 0.
  - Storage contents are not cleared. out_x data is don't-care while out_x_valid=0; the bench must not check it.
- in_ready is combinational: in_ready = !reset && !full[sel].
  - It depends only on sel and registered state. There is no path from any out_x_ready to in_ready.
  - There is no same-cycle pass-through.
- Push: when in_valid && in_ready, word in is written to FIFO[sel] at its write pointer. The write pointer increments mod DEPTH and the count increments.
- Pop: when out_x_valid && out_x_ready, the read pointer of FIFO x increments mod DEPTH and the count decrements.
  - out_x_ready while out_x_valid=0 has no effect.
- Latency: a word accepted at edge N is visible on out_x with out_x_valid=1 after edge N, i.e. one-cycle latency when the FIFO was empty.
- Ordering: each channel preserves acceptance order. There is no ordering relation between different channels.
- Stability: while out_x_valid=1 and out_x_ready=0, out_x and out_x_valid hold constant.
- Simultaneous push and pop on the same channel:
  - Count unchanged; both pointers advance.
  - When the FIFO is full, in_ready=0, so the push is refused even though a pop occurs that cycle.
- Full: count==DEPTH. A word addressed to a full channel stalls the producer; other channels keep draining.
- Empty: count==0; out_x_valid=0.
- Wrap-around: pointers are clog2(DEPTH) bits wide and wrap naturally. The count is clog2(DEPTH)+1 bits wide, which disambiguates full from empty.
- sel or in changing while in_valid=0 has no effect.
- Reset mid-operation: all buffered words are discarded and never appear on any output. Handshakes in the reset cycle are ignored.
- There is no central state machine. Each channel's state is its count, taking values EMPTY(0) .. FULL(DEPTH):
  - push only: count+1
  - pop only: count-1
  - both, or neither: unchanged
- Demux decode: one-hot write enable per channel, we[i] = in_valid && in_ready && (sel==i).

Decomposition:
- Shared package my_dmux_pkg:
  - constant CHANNELS=4
  - typedef for the 2-bit channel select, with named constants CH_A..CH_D
- Sub-module my_fifo_chan (parameters WIDTH, DEPTH):
  - ports clk, reset, wr_en, wr_data, full, rd_en, rd_data, not_empty
  - instantiated four times
- The top level holds only the sel decode, the in_ready mux and the port wiring.

Test Plan:
1. Reset: hold reset 2 cycles with in_valid=1 -> in_ready=0 during reset; after release all out_x_valid=0 and in_ready=1.
2. Routing: sel=2, in=16'hBEEF, in_valid for 1 cycle, all ready=1 -> next cycle out_c=BEEF, out_c_valid=1 for exactly 1 cycle; a/b/d valid stay 0.
3. Backpressure isolation: out_a_ready=0; send 0x0011, 0x0022, 0x0033 to sel=0 -> first two accepted, in_ready=0 on the third. Switch sel=1 with 0x0044 -> accepted, out_b=0044 next cycle. Raise out_a_ready -> 0011 then 0022 pop, then 0033 is accepted.
4. Order/wrap: stream 0x0001..0x0009 to sel=3 with out_d_ready toggling 1,0,0,1 pattern -> out_d delivers 0001..0009 in order, no loss or duplication; pointers wrap at least 4 times.
5. Throughput: channel b holds 1 word, in_valid=1, sel=1 and out_b_ready=1 continuously for 8 cycles -> one word accepted and one delivered every cycle; out_b_valid stays 1 and the count stays 1.
6. Reset mid-operation: channels a and d each hold 2 words; assert reset 1 cycle -> next cycle all out_x_valid=0. Send 0x0AAA to sel=0 -> out_a delivers 0AAA first, and no pre-reset word ever appears.

Source files
------------

// File: rtl/my_dmux_pkg.sv
// Shared definitions for the buffered 4-way demultiplexer.
package my_dmux_pkg;

  localparam int CHANNELS = 4;

  typedef logic [1:0] chan_sel_t;

  localparam chan_sel_t CH_A = 2'd0;
  localparam chan_sel_t CH_B = 2'd1;
  localparam chan_sel_t CH_C = 2'd2;
  localparam chan_sel_t CH_D = 2'd3;

endpackage

// File: rtl/my_dmux_4_way_buf_if.sv
// Producer-side stream plus the four consumer channels of the demux.
interface my_dmux_4_way_buf_if
  import my_dmux_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] in;
  chan_sel_t        sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic             out_a_valid;
  logic             out_b_valid;
  logic             out_c_valid;
  logic             out_d_valid;
  logic             out_a_ready;
  logic             out_b_ready;
  logic             out_c_ready;
  logic             out_d_ready;

  // The master drives the input stream and the consumer readies.
  modport master (
    output in, sel, in_valid,
    output out_a_ready, out_b_ready, out_c_ready, out_d_ready,
    input  in_ready,
    input  out_a, out_b, out_c, out_d,
    input  out_a_valid, out_b_valid, out_c_valid, out_d_valid
  );

  modport slave (
    input  in, sel, in_valid,
    input  out_a_ready, out_b_ready, out_c_ready, out_d_ready,
    output in_ready,
    output out_a, out_b, out_c, out_d,
    output out_a_valid, out_b_valid, out_c_valid, out_d_valid
  );

endinterface

// File: rtl/my_fifo_chan.sv
// Single-clock FIFO for one demux channel; the head word is always
// presented on rd_data.
module my_fifo_chan #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             not_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign full      = (count == CW'(DEPTH));
  assign not_empty = (count != '0);
  assign push      = wr_en && !full;
  assign pop       = rd_en && not_empty;
  assign rd_data   = mem[rd_ptr];

  // The extra count bit tells full apart from empty when the pointers match.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left uncleared on reset.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/my_dmux_4_way_buf.sv
// Buffered 4-way demultiplexer: routes each accepted word to the FIFO of
// the channel named by sel.
module my_dmux_4_way_buf
  import my_dmux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input logic                clk,
  input logic                reset,
  my_dmux_4_way_buf_if.slave bus
);

  logic [CHANNELS-1:0] we;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] not_empty;
  logic [CHANNELS-1:0] rd_en;
  logic [WIDTH-1:0]    rd_data [CHANNELS];
  logic                in_ready;

  // Readiness looks only at the addressed channel, never at consumer readies.
  assign in_ready     = !reset && !full[bus.sel];
  assign bus.in_ready = in_ready;

  always_comb begin
    we = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      we[i] = bus.in_valid && in_ready && (bus.sel == chan_sel_t'(i));
    end
  end

  assign rd_en = {bus.out_d_ready, bus.out_c_ready, bus.out_b_ready, bus.out_a_ready};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    my_fifo_chan #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (we[g]),
      .wr_data   (bus.in),
      .full      (full[g]),
      .rd_en     (rd_en[g]),
      .rd_data   (rd_data[g]),
      .not_empty (not_empty[g])
    );
  end

  assign bus.out_a       = rd_data[CH_A];
  assign bus.out_b       = rd_data[CH_B];
  assign bus.out_c       = rd_data[CH_C];
  assign bus.out_d       = rd_data[CH_D];
  assign bus.out_a_valid = not_empty[CH_A];
  assign bus.out_b_valid = not_empty[CH_B];
  assign bus.out_c_valid = not_empty[CH_C];
  assign bus.out_d_valid = not_empty[CH_D];

endmodule

// File: tb/tb_my_dmux_4_way_buf.sv
// Self-checking bench for my_dmux_4_way_buf: directed scenarios plus a
// random phase, all checked against a queue-based model of the channels.
module tb_my_dmux_4_way_buf;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic clk;
  logic reset;
  logic [3:0] rdy;
  logic [WIDTH-1:0] dout [4];
  logic [3:0] dvalid;

  int checks;
  int errors;
  bit model_live;
  bit log_d;
  logic [WIDTH-1:0] q [4][$];
  logic [WIDTH-1:0] d_log [$];

  my_dmux_4_way_buf_if #(.WIDTH(WIDTH)) bus ();

  my_dmux_4_way_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.out_a_ready = rdy[0];
  assign bus.out_b_ready = rdy[1];
  assign bus.out_c_ready = rdy[2];
  assign bus.out_d_ready = rdy[3];
  assign dout[0] = bus.out_a;
  assign dout[1] = bus.out_b;
  assign dout[2] = bus.out_c;
  assign dout[3] = bus.out_d;
  assign dvalid  = {bus.out_d_valid, bus.out_c_valid, bus.out_b_valid, bus.out_a_valid};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [1:0] s,
                               input logic [WIDTH-1:0] d, input logic [3:0] rd);
    @(posedge clk);
    #1;
    reset        = r;
    bus.in_valid = v;
    bus.sel      = s;
    bus.in       = d;
    rdy          = rd;
    @(negedge clk);
  endtask

  // Reference model: one FIFO queue per channel, updated from pre-edge inputs.
  always @(posedge clk) begin
    bit push_ok;
    if (reset) begin
      for (int c = 0; c < 4; c++) q[c].delete();
      model_live = 1'b1;
    end else if (model_live) begin
      push_ok = bus.in_valid && (q[bus.sel].size() < DEPTH);
      for (int c = 0; c < 4; c++) begin
        if (rdy[c] && q[c].size() > 0) void'(q[c].pop_front());
      end
      if (push_ok) q[bus.sel].push_back(bus.in);
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("in_ready", {31'd0, bus.in_ready},
                  {31'd0, !reset && (q[bus.sel].size() < DEPTH)});
      for (int c = 0; c < 4; c++) begin
        checkOutput($sformatf("valid_%0d", c), {31'd0, dvalid[c]}, {31'd0, q[c].size() > 0});
        if (q[c].size() > 0)
          checkOutput($sformatf("data_%0d", c), {16'd0, dout[c]}, {16'd0, q[c][0]});
      end
      if (log_d && !reset && dvalid[3] && rdy[3]) d_log.push_back(dout[3]);
    end
  end

  initial begin
    int idx;
    int cyc;
    logic acc;
    logic [3:0] pat;

    checks = 0;
    errors = 0;
    model_live = 1'b0;
    log_d = 1'b0;
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.sel = 2'd0;
    bus.in = 16'h1234;
    rdy = 4'hF;

    // Reset held with a valid word pending
    @(negedge clk);
    checkOutput("t1_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
    applyStimulus(1, 1, 0, 16'h1234, 4'hF);
    checkOutput("t1_ready_in_reset2", {31'd0, bus.in_ready}, 32'd0);
    applyStimulus(0, 0, 0, 16'h0000, 4'hF);
    checkOutput("t1_ready_after", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("t1_valids_after", {28'd0, dvalid}, 32'd0);

    // Routing to channel c
    applyStimulus(0, 1, 2, 16'hBEEF, 4'hF);
    applyStimulus(0, 0, 0, 16'h0000, 4'hF);
    checkOutput("t2_c_valid", {28'd0, dvalid}, 32'h4);
    checkOutput("t2_c_data", {16'd0, dout[2]}, 32'h0000BEEF);
    applyStimulus(0, 0, 0, 16'h0000, 4'hF);
    checkOutput("t2_c_gone", {28'd0, dvalid}, 32'd0);

    // Backpressure on a must not block b
    applyStimulus(0, 1, 0, 16'h0011, 4'b1110);
    applyStimulus(0, 1, 0, 16'h0022, 4'b1110);
    applyStimulus(0, 1, 0, 16'h0033, 4'b1110);
    checkOutput("t3_a_full_stall", {31'd0, bus.in_ready}, 32'd0);
    applyStimulus(0, 1, 1, 16'h0044, 4'b1110);
    checkOutput("t3_b_accept", {31'd0, bus.in_ready}, 32'd1);
    applyStimulus(0, 0, 0, 16'h0000, 4'b1110);
    checkOutput("t3_b_data", {16'd0, dout[1]}, 32'h00000044);
    applyStimulus(0, 1, 0, 16'h0033, 4'hF);
    checkOutput("t3_a_head1", {16'd0, dout[0]}, 32'h00000011);
    applyStimulus(0, 1, 0, 16'h0033, 4'hF);
    checkOutput("t3_a_head2", {16'd0, dout[0]}, 32'h00000022);
    checkOutput("t3_a_reopen", {31'd0, bus.in_ready}, 32'd1);
    applyStimulus(0, 0, 0, 16'h0000, 4'hF);
    checkOutput("t3_a_head3", {16'd0, dout[0]}, 32'h00000033);
    applyStimulus(0, 0, 0, 16'h0000, 4'hF);

    // Ordered stream through d with a 1,0,0,1 ready pattern
    pat = 4'b1001;
    idx = 1;
    cyc = 0;
    log_d = 1'b1;
    while (idx <= 9 && cyc < 100) begin
      applyStimulus(0, 1, 3, 16'(idx), {pat[cyc % 4], 3'b111});
      acc = bus.in_ready;
      if (acc) idx++;
      cyc++;
    end
    if (idx <= 9) checkOutput("t4_timeout", 32'(idx), 32'd10);
    cyc = 0;
    while (d_log.size() < 9 && cyc < 20) begin
      applyStimulus(0, 0, 0, 16'h0000, 4'hF);
      cyc++;
    end
    applyStimulus(0, 0, 0, 16'h0000, 4'hF);
    log_d = 1'b0;
    checkOutput("t4_count", 32'(d_log.size()), 32'd9);
    for (int i = 0; i < 9 && i < d_log.size(); i++)
      checkOutput($sformatf("t4_word_%0d", i), {16'd0, d_log[i]}, 32'(i + 1));

    // Full-rate streaming through b
    applyStimulus(0, 1, 1, 16'h5000, 4'b1101);
    applyStimulus(0, 0, 0, 16'h0000, 4'b1101);
    checkOutput("t5_b_holds", {31'd0, dvalid[1]}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 1, 1, 16'h5000 + 16'(k), 4'hF);
      checkOutput("t5_ready", {31'd0, bus.in_ready}, 32'd1);
      checkOutput("t5_valid", {31'd0, dvalid[1]}, 32'd1);
      checkOutput("t5_count", 32'(q[1].size()), 32'd1);
    end
    applyStimulus(0, 0, 0, 16'h0000, 4'hF);
    checkOutput("t5_last", {16'd0, dout[1]}, 32'h00005008);
    applyStimulus(0, 0, 0, 16'h0000, 4'hF);

    // Reset discards buffered words
    applyStimulus(0, 1, 0, 16'h0A01, 4'b0110);
    applyStimulus(0, 1, 0, 16'h0A02, 4'b0110);
    applyStimulus(0, 1, 3, 16'h0D01, 4'b0110);
    applyStimulus(0, 1, 3, 16'h0D02, 4'b0110);
    applyStimulus(0, 0, 0, 16'h0000, 4'b0110);
    checkOutput("t6_before", {28'd0, dvalid}, 32'h9);
    applyStimulus(1, 1, 1, 16'hBBBB, 4'hF);
    checkOutput("t6_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
    applyStimulus(0, 1, 0, 16'h0AAA, 4'b0110);
    checkOutput("t6_cleared", {28'd0, dvalid}, 32'd0);
    applyStimulus(0, 0, 0, 16'h0000, 4'b0110);
    checkOutput("t6_a_valid", {28'd0, dvalid}, 32'h1);
    checkOutput("t6_a_data", {16'd0, dout[0]}, 32'h00000AAA);
    applyStimulus(0, 0, 0, 16'h0000, 4'hF);

    // Random traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                    2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom));
    end
    for (int n = 0; n < 4; n++) applyStimulus(0, 0, 0, 16'h0000, 4'hF);
    checkOutput("drained", {28'd0, dvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
